// File: rtl/alu_share_arb.sv
// alu_share_arb
// Shares one combinational ALU between two requesters, using round-robin
// arbitration. The granted operation drives the ALU. The block registers
// the result into a single-entry response buffer and tags it with the
// requester id.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rN_valid/ready           request handshake for requester N (N = 0, 1)
//   rN_a, rN_b, rN_op        operands and 4-bit ALU control code
//   alu_a, alu_b, alu_ctrl   drive to the shared ALU (zero when idle)
//   alu_result, alu_zero     combinational ALU outputs
//   rsp_valid/ready          response handshake
//   rsp_id                   requester that issued the buffered result
//   rsp_result, rsp_zero     registered ALU outputs
//   ops_done                 wrapping count of accepted operations
module alu_share_arb #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic [3:0]       r0_op,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   input  logic [3:0]       r1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [CNT_W-1:0] ops_done
);

   localparam logic [0:0] P0 = 1'b0;
   localparam logic [0:0] P1 = 1'b1;

   logic [0:0] prio;
   logic       can_accept;
   logic       gnt;      // a grant is made this cycle
   logic       gnt_id;   // index of the granted requester

   // Draining the buffered result frees the slot in the same cycle.
   assign can_accept = !rsp_valid || rsp_ready;

   // The priority pointer only matters when both requesters are valid.
   // Otherwise the single valid requester wins. Reset blocks grants so
   // that no ready is issued in reset cycles.
   always_comb begin
      gnt    = !rst && can_accept && (r0_valid || r1_valid);
      gnt_id = (r0_valid && r1_valid) ? (prio == P1) : r1_valid;
   end

   assign r0_ready = gnt && !gnt_id;
   assign r1_ready = gnt &&  gnt_id;

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = 4'b0000;
      if (gnt) begin
         alu_a    = gnt_id ? r1_a  : r0_a;
         alu_b    = gnt_id ? r1_b  : r0_b;
         alu_ctrl = gnt_id ? r1_op : r0_op;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         ops_done   <= '0;
         prio       <= P0;
      end else if (gnt) begin
         // An accept overwrites any result that is drained in the same
         // cycle, so there is no bubble.
         rsp_valid  <= 1'b1;
         rsp_id     <= gnt_id;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
         ops_done   <= ops_done + 1'b1;
         prio       <= gnt_id ? P0 : P1;
      end else if (rsp_valid && rsp_ready) begin
         // Drain only. The payload keeps its stale value.
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb. A small behavioural ALU closes the loop.
// A second instance with CNT_W=4 receives the same stimulus and exercises
// counter wrap.
module tb_alu_share_arb;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          r0_valid, r1_valid, rsp_ready;
   logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
   logic [3:0]    r0_op, r1_op;

   logic          r0_ready, r1_ready, rsp_valid, rsp_id, rsp_zero;
   logic [W-1:0]  alu_a, alu_b, alu_result, rsp_result;
   logic [3:0]    alu_ctrl;
   logic          alu_zero;
   logic [15:0]   ops_done;

   logic          r0_ready4, r1_ready4, rsp_valid4, rsp_id4, rsp_zero4;
   logic [W-1:0]  alu_a4, alu_b4, alu_result4, rsp_result4;
   logic [3:0]    alu_ctrl4;
   logic          alu_zero4;
   logic [3:0]    ops_done4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
      case (c)
         4'b0010: alu_f = a + b;
         4'b0110: alu_f = a - b;
         4'b0000: alu_f = a & b;
         4'b0001: alu_f = a | b;
         default: alu_f = '0;
      endcase
   endfunction

   assign alu_result  = alu_f(alu_a, alu_b, alu_ctrl);
   assign alu_zero    = (alu_result == '0);
   assign alu_result4 = alu_f(alu_a4, alu_b4, alu_ctrl4);
   assign alu_zero4   = (alu_result4 == '0);

   alu_share_arb #(.WIDTH(W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .ops_done(ops_done)
   );

   alu_share_arb #(.WIDTH(W), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready4), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready4), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_ctrl(alu_ctrl4),
      .alu_result(alu_result4), .alu_zero(alu_zero4),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4),
      .rsp_result(rsp_result4), .rsp_zero(rsp_zero4), .ops_done(ops_done4)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b0;
      r0_valid = 1'b1; r1_valid = 1'b1;
      r0_a = '0; r0_b = '0; r0_op = 4'b0000;
      r1_a = '0; r1_b = '0; r1_op = 4'b0000;

      // Reset: no readys even with both requesters valid.
      tick(); settle();
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_r0_ready4", r0_ready4, 0);
      chk("rst_r1_ready4", r1_ready4, 0);
      tick();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_zero", rsp_zero, 0);
      chk("rst_ops_done", ops_done, 0);
      chk("rst_ops_done4", ops_done4, 0);

      // r0 add 5 + 7.
      rst = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
      r0_a = 5; r0_b = 7; r0_op = 4'b0010;
      settle();
      chk("add_r0_ready", r0_ready, 1);
      chk("add_r1_ready", r1_ready, 0);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_ctrl", alu_ctrl, 4'b0010);
      tick();
      r0_valid = 1'b0;
      chk("add_rsp_valid", rsp_valid, 1);
      chk("add_rsp_id", rsp_id, 0);
      chk("add_rsp_result", rsp_result, 12);
      chk("add_rsp_zero", rsp_zero, 0);
      chk("add_ops_done", ops_done, 1);

      // Drain with nothing pending: ALU is idle-driven and the slot empties.
      settle();
      chk("idle_alu_a", alu_a, 0);
      chk("idle_alu_ctrl", alu_ctrl, 0);
      tick();
      chk("drain_rsp_valid", rsp_valid, 0);

      // Both valid, rsp_ready high. prio is P1 after the r0 grant, so r1 wins first.
      r0_valid = 1'b1; r0_a = 9; r0_b = 9; r0_op = 4'b0110;
      r1_valid = 1'b1; r1_a = 32'hF0; r1_b = 32'h0F; r1_op = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_r1_ready", r1_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_r0_ready", r0_ready, (i % 2 == 0) ? 0 : 1);
         tick();
         chk("rr_rsp_valid", rsp_valid, 1);
         chk("rr_rsp_id", rsp_id, (i % 2 == 0) ? 1 : 0);
         chk("rr_rsp_result", rsp_result, (i % 2 == 0) ? 32'hFF : 0);
         chk("rr_rsp_zero", rsp_zero, (i % 2 == 0) ? 0 : 1);
      end
      chk("rr_ops_done", ops_done, 5);

      // Backpressure for 3 cycles. Everything is frozen (id 0 result 0, prio P1).
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_r0_ready", r0_ready, 0);
         chk("bp_r1_ready", r1_ready, 0);
         tick();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_id", rsp_id, 0);
         chk("bp_rsp_zero", rsp_zero, 1);
         chk("bp_ops_done", ops_done, 5);
      end
      rsp_ready = 1'b1;
      settle();
      chk("rel_r1_ready", r1_ready, 1);
      tick();
      chk("rel_rsp_valid", rsp_valid, 1);
      chk("rel_rsp_id", rsp_id, 1);
      chk("rel_rsp_result", rsp_result, 32'hFF);
      chk("rel_ops_done", ops_done, 6);

      // r1 and with disjoint masks, then an unsupported op.
      r0_valid = 1'b0;
      r1_a = 32'hFFFF0000; r1_b = 32'h0000FFFF; r1_op = 4'b0000;
      settle();
      chk("and_r1_ready", r1_ready, 1);
      tick();
      chk("and_rsp_id", rsp_id, 1);
      chk("and_rsp_result", rsp_result, 0);
      chk("and_rsp_zero", rsp_zero, 1);
      r1_a = 3; r1_b = 4; r1_op = 4'b1111;
      settle();
      chk("bad_r1_ready", r1_ready, 1);
      chk("bad_alu_ctrl", alu_ctrl, 4'b1111);
      tick();
      chk("bad_rsp_result", rsp_result, 0);
      chk("bad_rsp_zero", rsp_zero, 1);
      chk("bad_ops_done", ops_done, 8);

      // Drain only: payload stays stale.
      r1_valid = 1'b0;
      tick();
      chk("stale_rsp_valid", rsp_valid, 0);
      chk("stale_rsp_id", rsp_id, 1);

      // prio is P0 here. Both valid: r0 wins, and prio then moves to P1.
      r0_valid = 1'b1; r0_a = 1; r0_b = 1; r0_op = 4'b0010;
      r1_valid = 1'b1; r1_a = 32'hF0; r1_b = 32'h0F; r1_op = 4'b0001;
      tick();
      chk("pre_rst_rsp_valid", rsp_valid, 1);
      chk("pre_rst_result", rsp_result, 2);
      chk("pre_rst_ops_done", ops_done, 9);
      rsp_ready = 1'b0; rst = 1'b1;
      settle();
      chk("mid_rst_r0_ready", r0_ready, 0);
      chk("mid_rst_r1_ready", r1_ready, 0);
      tick();
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_ops_done", ops_done, 0);
      rst = 1'b0; rsp_ready = 1'b1;
      settle();
      chk("post_rst_r0_ready", r0_ready, 1);
      chk("post_rst_r1_ready", r1_ready, 0);
      tick();
      chk("post_rst_rsp_id", rsp_id, 0);
      chk("post_rst_ops_done", ops_done, 1);

      // Sixteen more operations: 17 since reset, so the 4-bit counter wraps to 1.
      for (int i = 0; i < 16; i++) tick();
      chk("wrap_ops_done16", ops_done, 17);
      chk("wrap_ops_done4", ops_done4, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
